enemy_path_controller: RTL and testbench

Per-enemy motion sequencer that sits directly upstream of the polar-to-screen coordinate lookup. It spawns an enemy at the playfield centre on a chosen angle and advances it radially once per video frame. It drives the lookup's distance (0..207) and angle (0..15) inputs and reports kill, escape and explosion status to game logic. One instance exists per on-screen enemy slot.

---
 rtl/enemy_path_controller.sv | 124 ++++++++++++
 tb/tb_enemy_path_controller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/enemy_path_controller.sv
// Radial motion sequencer for one enemy slot: spawn, per-frame advance,
// escape at the playfield edge, and a timed explosion after a hit.
module enemy_path_controller #(
  parameter int MAX_DIST       = 208,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic [3:0] spawn_angle,
  input  logic [2:0] speed,
  input  logic       hit,
  output logic [7:0] distance,
  output logic [3:0] angle,
  output logic       active,
  output logic       exploding,
  output logic       killed,
  output logic       escaped,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    EXPLODE = 2'd2
  } state_e;

  localparam logic [8:0] MaxDist   = 9'(MAX_DIST);
  localparam logic [3:0] ExpFrames = 4'(EXPLODE_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] dist_q, dist_d;
  logic [3:0] angle_q, angle_d;
  logic [2:0] speed_q, speed_d;
  logic [3:0] cnt_q, cnt_d;
  logic       killed_q, killed_d;
  logic       escaped_q, escaped_d;
  logic [8:0] sum;

  // Full-width sum so an overshoot past the edge is seen, never wrapped.
  assign sum = {1'b0, dist_q} + {6'b0, speed_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dist_q    <= 8'd0;
      angle_q   <= 4'd0;
      speed_q   <= 3'd1;
      cnt_q     <= 4'd0;
      killed_q  <= 1'b0;
      escaped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dist_q    <= dist_d;
      angle_q   <= angle_d;
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
      killed_q  <= killed_d;
      escaped_q <= escaped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dist_d    = dist_q;
    angle_d   = angle_q;
    speed_d   = speed_q;
    cnt_d     = cnt_q;
    killed_d  = 1'b0;
    escaped_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (spawn) begin
          state_d = MOVE;
          dist_d  = 8'd0;
          angle_d = spawn_angle;
          speed_d = (speed == 3'd0) ? 3'd1 : speed;
        end
      end
      MOVE: begin
        if (hit) begin
          state_d  = EXPLODE;
          killed_d = 1'b1;
          cnt_d    = ExpFrames;
        end else if (frame_tick) begin
          if (sum < MaxDist) begin
            dist_d = sum[7:0];
          end else begin
            state_d   = IDLE;
            dist_d    = 8'd0;
            escaped_d = 1'b1;
          end
        end
      end
      EXPLODE: begin
        if (frame_tick) begin
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            dist_d  = 8'd0;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        dist_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    distance  = dist_q;
    angle     = angle_q;
    active    = (state_q == MOVE);
    exploding = (state_q == EXPLODE);
    busy      = active | exploding;
    killed    = killed_q;
    escaped   = escaped_q;
  end

endmodule

// File: tb/tb_enemy_path_controller.sv
// Directed scoreboard bench for enemy_path_controller.
// Stimulus queues per-edge expectations; a monitor pops and compares.
module tb_enemy_path_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       spawn = 1'b0;
  logic [3:0] spawn_angle = 4'd0;
  logic [2:0] speed = 3'd0;
  logic       hit = 1'b0;
  logic [7:0] distance;
  logic [3:0] angle;
  logic       active, exploding, killed, escaped, busy;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic [3:0] a;
    logic       act;
    logic       expl;
    logic       kill;
    logic       esc;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;

  enemy_path_controller #(.MAX_DIST(208), .EXPLODE_FRAMES(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .spawn(spawn), .spawn_angle(spawn_angle), .speed(speed),
    .hit(hit), .distance(distance), .angle(angle),
    .active(active), .exploding(exploding), .killed(killed),
    .escaped(escaped), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_tests++;
        if (distance !== e.d || angle !== e.a || active !== e.act ||
            exploding !== e.expl || killed !== e.kill ||
            escaped !== e.esc || busy !== e.busy) begin
          n_fail++;
          $display("FAIL step%0d got d=%0d a=%0d act=%b exp=%b kil=%b esc=%b busy=%b want d=%0d a=%0d act=%b exp=%b kil=%b esc=%b busy=%b",
                   e.id, distance, angle, active, exploding, killed,
                   escaped, busy, e.d, e.a, e.act, e.expl, e.kill,
                   e.esc, e.busy);
        end
      end
    end
  end

  task automatic step(input logic r, input logic sp,
                      input logic [3:0] a, input logic [2:0] s,
                      input logic tk, input logic h,
                      input logic [7:0] ed, input logic [3:0] ea,
                      input logic eact, input logic eexp,
                      input logic ekill, input logic eesc);
    exp_t e;
    rst_n       = r;
    spawn       = sp;
    spawn_angle = a;
    speed       = s;
    frame_tick  = tk;
    hit         = h;
    e.id   = n_step;
    e.d    = ed;
    e.a    = ea;
    e.act  = eact;
    e.expl = eexp;
    e.kill = ekill;
    e.esc  = eesc;
    e.busy = eact | eexp;
    n_step++;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : stim
    // reset, then spawn angle 5 speed 3
    step(0,0,0,0,0,0, 0,0,0,0,0,0);
    step(0,0,0,0,0,0, 0,0,0,0,0,0);
    step(1,1,5,3,0,0, 0,5,1,0,0,0);
    for (int i = 1; i <= 4; i++)
      step(1,0,0,0,1,0, 8'(3*i),5,1,0,0,0);
    step(1,1,9,5,0,0, 12,5,1,0,0,0);
    step(1,0,0,0,0,0, 12,5,1,0,0,0);
    step(0,0,0,0,0,0, 0,0,0,0,0,0);

    // speed 7 escape from 203; spawn on the escape cycle is ignored
    step(1,1,2,7,0,0, 0,2,1,0,0,0);
    for (int i = 1; i <= 29; i++)
      step(1,0,0,0,1,0, 8'(7*i),2,1,0,0,0);
    step(1,1,6,7,1,0, 0,2,0,0,0,1);
    step(1,0,0,0,0,0, 0,2,0,0,0,0);

    // speed 0 acts as 1: reaches 207 then escapes
    step(1,1,3,0,0,0, 0,3,1,0,0,0);
    for (int i = 1; i <= 207; i++)
      step(1,0,0,0,1,0, 8'(i),3,1,0,0,0);
    step(1,0,0,0,1,0, 0,3,0,0,0,1);
    step(1,0,0,0,0,0, 0,3,0,0,0,0);

    // hit together with tick at distance 40
    step(1,1,4,5,0,0, 0,4,1,0,0,0);
    for (int i = 1; i <= 8; i++)
      step(1,0,0,0,1,0, 8'(5*i),4,1,0,0,0);
    step(1,0,0,0,1,1, 40,4,0,1,1,0);
    step(1,0,0,0,0,1, 40,4,0,1,0,0);
    for (int i = 1; i <= 7; i++)
      step(1,0,0,0,1,0, 40,4,0,1,0,0);
    step(1,1,11,2,1,0, 0,4,0,0,0,0);
    step(1,1,11,2,0,0, 0,11,1,0,0,0);

    // reset mid-MOVE at distance 100
    for (int i = 1; i <= 50; i++)
      step(1,0,0,0,1,0, 8'(2*i),11,1,0,0,0);
    step(0,0,0,0,1,1, 0,0,0,0,0,0);
    step(1,0,0,0,0,0, 0,0,0,0,0,0);

    // reset mid-EXPLODE
    step(1,1,7,1,0,0, 0,7,1,0,0,0);
    step(1,0,0,0,1,0, 1,7,1,0,0,0);
    step(1,0,0,0,0,1, 1,7,0,1,1,0);
    step(0,0,0,0,1,0, 0,0,0,0,0,0);
    step(1,0,0,0,0,0, 0,0,0,0,0,0);

    repeat (2) @(posedge clk);
    #3;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
